lieat_pipe_skid_stage: RTL and testbench

//  Registered valid/ready stage between two lieat pipeline stages (e.g. IF->ID, EX->MEM).

---
 rtl/lieat_pipe_pkg.sv | 14 +
 rtl/lieat_pipe_skid_stage_if.sv | 26 ++
 rtl/lieat_pipe_skid_reg.sv | 30 +++
 rtl/lieat_pipe_skid_stage.sv | 142 ++++++++++++++
 tb/tb_lieat_pipe_skid_stage.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/lieat_pipe_pkg.sv
// Shared definitions for the lieat pipeline skid stage.
//  - state_e          : stage occupancy encoding (EMPTY/BUSY/FULL)
//  - RST_DATA_DEFAULT : payload value loaded into data registers on reset
package lieat_pipe_pkg;

  typedef enum logic [1:0] {
    StEmpty = 2'b00,
    StBusy  = 2'b01,
    StFull  = 2'b10
  } state_e;

  localparam logic [31:0] RST_DATA_DEFAULT = 32'h8000_0000;

endpackage

// File: rtl/lieat_pipe_skid_stage_if.sv
// Valid/ready handshake bundle carrying one DW-wide payload.
//  valid : producer has a payload
//  ready : consumer can accept
//  data  : payload
// master = producer side, slave = consumer side.
interface lieat_pipe_skid_stage_if #(
  parameter int unsigned DW = 32
);

  logic          valid;
  logic          ready;
  logic [DW-1:0] data;

  modport master (
    output valid,
    output data,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    output ready
  );

endinterface

// File: rtl/lieat_pipe_skid_reg.sv
// DW-wide load-enabled register with synchronous active-high reset.
//  i_clock : clock
//  i_reset : synchronous reset, loads RST_DATA (wins over i_load)
//  i_load  : capture i_d on the next posedge
//  i_d     : next value
//  o_q     : registered value
module lieat_pipe_skid_reg #(
  parameter int unsigned      DW       = 32,
  parameter logic [DW-1:0]    RST_DATA = '0
) (
  input  logic          i_clock,
  input  logic          i_reset,
  input  logic          i_load,
  input  logic [DW-1:0] i_d,
  output logic [DW-1:0] o_q
);

  logic [DW-1:0] r_q;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_q <= RST_DATA;
    end else if (i_load) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/lieat_pipe_skid_stage.sv
// Registered valid/ready pipeline stage with a one-entry skid buffer.
// Upstream ready comes only from flops, so no combinational path runs from
// downstream ready back to upstream ready. Sustains one transfer per cycle.
//  i_clock     : clock, all state on posedge
//  i_reset     : synchronous active-high reset
//  i_flush     : synchronous flush, drops all held entries
//  up_if       : upstream handshake (stage is consumer)
//  dn_if       : downstream handshake (stage is producer), data = main register
//  o_stall_cnt : cycles with out_valid & ~out_ready & ~flush, saturating
// Optional feature macro: LIEAT_PIPE_STALL_CNT_EN builds the stall counter;
// without it o_stall_cnt is constant zero.
module lieat_pipe_skid_stage
  import lieat_pipe_pkg::*;
#(
  parameter int unsigned   DW       = 32,
  parameter logic [DW-1:0] RST_DATA = DW'(RST_DATA_DEFAULT),
  parameter int unsigned   CW       = 16
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic                   i_flush,
  lieat_pipe_skid_stage_if.slave  up_if,
  lieat_pipe_skid_stage_if.master dn_if,
  output logic [CW-1:0]          o_stall_cnt
);

  state_e        r_state;
  state_e        w_state_d;
  logic          r_reset_q;
  logic          w_in_ready;
  logic          w_out_valid;
  logic          w_in_fire;
  logic          w_out_fire;
  logic          w_main_load;
  logic          w_main_sel_skid;
  logic          w_skid_load;
  logic [DW-1:0] w_main_d;
  logic [DW-1:0] w_main_q;
  logic [DW-1:0] w_skid_q;

  // Delayed reset keeps in_ready low for the whole reset window while still
  // coming straight from a flop.
  always_ff @(posedge i_clock) begin
    r_reset_q <= i_reset;
  end

  assign w_in_ready  = (r_state != StFull) & ~r_reset_q;
  assign w_out_valid = (r_state != StEmpty);
  assign w_in_fire   = up_if.valid & w_in_ready;
  assign w_out_fire  = w_out_valid & dn_if.ready;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= StEmpty;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d       = r_state;
    w_main_load     = 1'b0;
    w_main_sel_skid = 1'b0;
    w_skid_load     = 1'b0;
    if (i_flush) begin
      // Handshakes in the flush cycle are discarded; data registers keep their contents.
      w_state_d = StEmpty;
    end else begin
      unique case (r_state)
        StEmpty: begin
          if (w_in_fire) begin
            w_state_d   = StBusy;
            w_main_load = 1'b1;
          end
        end
        StBusy: begin
          if (w_in_fire && w_out_fire) begin
            w_main_load = 1'b1;
          end else if (w_in_fire) begin
            w_state_d   = StFull;
            w_skid_load = 1'b1;
          end else if (w_out_fire) begin
            w_state_d = StEmpty;
          end
        end
        StFull: begin
          if (w_out_fire) begin
            w_state_d       = StBusy;
            w_main_load     = 1'b1;
            w_main_sel_skid = 1'b1;
          end
        end
        default: w_state_d = StEmpty;
      endcase
    end
  end

  assign w_main_d = w_main_sel_skid ? w_skid_q : up_if.data;

  lieat_pipe_skid_reg #(
    .DW       (DW),
    .RST_DATA (RST_DATA)
  ) u_main_reg (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_load  (w_main_load),
    .i_d     (w_main_d),
    .o_q     (w_main_q)
  );

  lieat_pipe_skid_reg #(
    .DW       (DW),
    .RST_DATA (RST_DATA)
  ) u_skid_reg (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_load  (w_skid_load),
    .i_d     (up_if.data),
    .o_q     (w_skid_q)
  );

  assign up_if.ready = w_in_ready;
  assign dn_if.valid = w_out_valid;
  assign dn_if.data  = w_main_q;

`ifdef LIEAT_PIPE_STALL_CNT_EN
  logic [CW-1:0] r_stall_cnt;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_stall_cnt <= '0;
    end else if (w_out_valid && !dn_if.ready && !i_flush && !(&r_stall_cnt)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign o_stall_cnt = r_stall_cnt;
`else
  assign o_stall_cnt = {CW{1'b0}};
`endif

endmodule

// File: tb/tb_lieat_pipe_skid_stage.sv
// Directed and scoreboard-checked bench for lieat_pipe_skid_stage (DW=32, CW=4).
module tb_lieat_pipe_skid_stage;

  localparam int unsigned DW = 32;
  localparam int unsigned CW = 4;
  localparam logic [31:0] RST_VAL = 32'h8000_0000;

`ifdef LIEAT_PIPE_STALL_CNT_EN
  localparam logic [31:0] STALL_SAT = 32'd15;
  localparam logic [31:0] STALL_5   = 32'd5;
`else
  localparam logic [31:0] STALL_SAT = 32'd0;
  localparam logic [31:0] STALL_5   = 32'd0;
`endif

  logic          clk;
  logic          rst;
  logic          flush;
  logic [CW-1:0] stall_cnt;

  int n_tests;
  int n_fail;

  lieat_pipe_skid_stage_if #(.DW(DW)) up_if ();
  lieat_pipe_skid_stage_if #(.DW(DW)) dn_if ();

  lieat_pipe_skid_stage #(
    .DW       (DW),
    .RST_DATA (RST_VAL),
    .CW       (CW)
  ) u_dut (
    .i_clock     (clk),
    .i_reset     (rst),
    .i_flush     (flush),
    .up_if       (up_if),
    .dn_if       (dn_if),
    .o_stall_cnt (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", tag, act, exp);
    end
  endtask

  // Advance one clock; outputs are stable 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int cycles);
    rst         = 1'b1;
    flush       = 1'b0;
    up_if.valid = 1'b0;
    dn_if.ready = 1'b0;
    for (int i = 0; i < cycles; i++) step();
    rst = 1'b0;
  endtask

  logic [31:0] sb_q[$];
  logic        m_in_fire;
  logic        m_out_fire;

  initial begin
    n_tests     = 0;
    n_fail      = 0;
    up_if.data  = '0;

    // 1: reset, then streaming.
    do_reset(3);
    check("rst_in_ready", 32'(up_if.ready), 32'd0);
    check("rst_out_valid", 32'(dn_if.valid), 32'd0);
    check("rst_out_data", dn_if.data, RST_VAL);
    check("rst_stall_cnt", 32'(stall_cnt), 32'd0);
    step();
    check("post_rst_in_ready", 32'(up_if.ready), 32'd1);
    check("post_rst_out_valid", 32'(dn_if.valid), 32'd0);
    up_if.valid = 1'b1;
    dn_if.ready = 1'b1;
    up_if.data  = 32'd1;
    for (int k = 1; k <= 8; k++) begin
      step();
      check("stream_valid", 32'(dn_if.valid), 32'd1);
      check("stream_data", dn_if.data, 32'(k));
      check("stream_in_ready", 32'(up_if.ready), 32'd1);
      up_if.data = 32'(k + 1);
    end
    up_if.valid = 1'b0;
    step();
    check("stream_drain", 32'(dn_if.valid), 32'd0);

    // 2: backpressure into FULL, then drain.
    dn_if.ready = 1'b0;
    up_if.valid = 1'b1;
    up_if.data  = 32'h0000_00AA;
    step();
    up_if.data = 32'h0000_00BB;
    step();
    up_if.valid = 1'b0;
    check("full_in_ready", 32'(up_if.ready), 32'd0);
    check("full_out_valid", 32'(dn_if.valid), 32'd1);
    check("full_out_data", dn_if.data, 32'h0000_00AA);
    step();
    step();
    check("full_hold_data", dn_if.data, 32'h0000_00AA);
    check("full_hold_in_ready", 32'(up_if.ready), 32'd0);
    dn_if.ready = 1'b1;
    step();
    check("drain_b_data", dn_if.data, 32'h0000_00BB);
    check("drain_b_valid", 32'(dn_if.valid), 32'd1);
    check("drain_in_ready", 32'(up_if.ready), 32'd1);
    step();
    check("drain_empty", 32'(dn_if.valid), 32'd0);

    // 4: flush while FULL with both handshakes active.
    dn_if.ready = 1'b0;
    up_if.valid = 1'b1;
    up_if.data  = 32'h0000_0A01;
    step();
    up_if.data = 32'h0000_0A02;
    step();
    flush       = 1'b1;
    dn_if.ready = 1'b1;
    up_if.data  = 32'h0000_0C0C;
    step();
    flush       = 1'b0;
    up_if.valid = 1'b0;
    check("flush_out_valid", 32'(dn_if.valid), 32'd0);
    check("flush_in_ready", 32'(up_if.ready), 32'd1);
    check("flush_data_kept", dn_if.data, 32'h0000_0A01);
    for (int i = 0; i < 3; i++) begin
      step();
      check("flush_no_c", 32'(dn_if.valid), 32'd0);
    end

    // Flush in BUSY with an accepted input: the input is dropped.
    dn_if.ready = 1'b0;
    up_if.valid = 1'b1;
    up_if.data  = 32'h0000_0D01;
    step();
    flush      = 1'b1;
    up_if.data = 32'h0000_0D02;
    step();
    flush       = 1'b0;
    up_if.valid = 1'b0;
    check("flush_busy_valid", 32'(dn_if.valid), 32'd0);
    check("flush_busy_data", dn_if.data, 32'h0000_0D01);

    // 5: reset while BUSY.
    up_if.valid = 1'b1;
    up_if.data  = 32'h0000_0055;
    step();
    check("pre_rst_busy", 32'(dn_if.valid), 32'd1);
    rst         = 1'b1;
    up_if.valid = 1'b0;
    step();
    check("mid_rst_valid", 32'(dn_if.valid), 32'd0);
    check("mid_rst_data", dn_if.data, RST_VAL);
    check("mid_rst_in_ready", 32'(up_if.ready), 32'd0);
    rst = 1'b0;
    step();
    check("mid_rst_release", 32'(up_if.ready), 32'd1);

    // 6: stall counter, counted from a fresh reset.
    do_reset(2);
    step();
    up_if.valid = 1'b1;
    up_if.data  = 32'h0000_0066;
    step();
    up_if.valid = 1'b0;
    for (int i = 0; i < 5; i++) step();
    check("stall_cnt_5", 32'(stall_cnt), STALL_5);
    for (int i = 0; i < 15; i++) step();
    check("stall_cnt_sat", 32'(stall_cnt), STALL_SAT);
    check("stall_hold_data", dn_if.data, 32'h0000_0066);
    dn_if.ready = 1'b1;
    step();
    check("stall_drain", 32'(dn_if.valid), 32'd0);

    // 3: random traffic against a FIFO scoreboard (depth 2).
    sb_q.delete();
    for (int c = 0; c < 10000; c++) begin
      up_if.valid = ($urandom_range(0, 3) != 0);
      dn_if.ready = ($urandom_range(0, 2) != 0);
      up_if.data  = $urandom;
      check("rnd_out_valid", 32'(dn_if.valid), 32'(sb_q.size() > 0));
      check("rnd_in_ready", 32'(up_if.ready), 32'(sb_q.size() < 2));
      if (sb_q.size() > 0) check("rnd_out_data", dn_if.data, sb_q[0]);
      m_in_fire  = up_if.valid && (sb_q.size() < 2);
      m_out_fire = dn_if.ready && (sb_q.size() > 0);
      step();
      if (m_out_fire) void'(sb_q.pop_front());
      if (m_in_fire) sb_q.push_back(up_if.data);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
